// File: rtl/ahci_int_pkg.sv
// Shared types and default constants for the AHCI interrupt controller.
// Also provides saturating increment helpers for its counters.
package ahci_int_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MSI_REQ     = 3'd1,
        HOLDOFF     = 3'd2,
        INTX_AREQ   = 3'd3,
        INTX_ACTIVE = 3'd4,
        INTX_DREQ   = 3'd5
    } int_state_t;

    localparam int unsigned HOLDOFF_CYCLES_DEF = 100000;
    localparam int unsigned RDY_TIMEOUT_DEF    = 1024;
    localparam logic [7:0]  MSI_VECTOR_DEF     = 8'h00;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahci_int_ctrl_sync2.sv
// Two-flop synchronizer used to bring asynchronous level inputs into clk.
module ahci_int_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ahci_int_ctrl.sv
// Turns the BAR block's int_enable level into MSI or INTx cfg_interrupt handshakes.
// Optional AHCI_INT_COUNT_EN adds a saturating int_count of accepted requests.
module ahci_int_ctrl
    import ahci_int_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
    parameter int unsigned RDY_TIMEOUT    = RDY_TIMEOUT_DEF,
    parameter logic [7:0]  MSI_VECTOR     = MSI_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_enable,
    input  logic        int_mask,
    input  logic        cfg_interrupt_msienable,
    input  logic        cfg_interrupt_rdy,
    output logic        cfg_interrupt,
    output logic        cfg_interrupt_assert,
    output logic [7:0]  cfg_interrupt_di,
    output logic        int_busy,
    output logic        int_timeout
`ifdef AHCI_INT_COUNT_EN
    ,
    output logic [31:0] int_count
`endif
);

    localparam logic [31:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 32'd0;
    localparam logic [31:0] TMO_LAST  = (RDY_TIMEOUT > 0) ? RDY_TIMEOUT - 1 : 32'd0;

    int_state_t  state_reg;
    logic        irq_reg;
    logic        assert_reg;
    logic [7:0]  di_reg;
    logic [31:0] hold_cnt_reg;
    logic [15:0] tmo_cnt_reg;
    logic        timeout_reg;
    logic        ie_s;
    logic        tmo_hit;

    ahci_int_sync2 #(.WIDTH(1)) u_ie_sync (
        .clk (clk),
        .rst (rst),
        .d   (int_enable),
        .q   (ie_s)
    );

    // Rdy is checked before tmo_hit so a same-cycle rdy counts as accepted.
    assign tmo_hit = ({16'd0, tmo_cnt_reg} >= TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            irq_reg      <= 1'b0;
            assert_reg   <= 1'b0;
            di_reg       <= 8'h00;
            hold_cnt_reg <= 32'd0;
            tmo_cnt_reg  <= 16'd0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= 32'd0;
                    tmo_cnt_reg  <= 16'd0;
                    if (ie_s && !int_mask) begin
                        irq_reg <= 1'b1;
                        if (cfg_interrupt_msienable) begin
                            state_reg  <= MSI_REQ;
                            assert_reg <= 1'b0;
                            di_reg     <= MSI_VECTOR;
                        end else begin
                            state_reg  <= INTX_AREQ;
                            assert_reg <= 1'b1;
                            di_reg     <= 8'h00;
                        end
                    end
                end

                MSI_REQ: begin
                    tmo_cnt_reg <= sat_inc16(tmo_cnt_reg);
                    if (cfg_interrupt_rdy || tmo_hit) begin
                        irq_reg      <= 1'b0;
                        di_reg       <= 8'h00;
                        hold_cnt_reg <= 32'd0;
                        state_reg    <= HOLDOFF;
                        if (!cfg_interrupt_rdy) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end

                HOLDOFF: begin
                    if (hold_cnt_reg >= HOLD_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= sat_inc32(hold_cnt_reg);
                    end
                end

                INTX_AREQ: begin
                    tmo_cnt_reg <= sat_inc16(tmo_cnt_reg);
                    if (cfg_interrupt_rdy) begin
                        irq_reg    <= 1'b0;
                        assert_reg <= 1'b0;
                        state_reg  <= INTX_ACTIVE;
                    end else if (tmo_hit) begin
                        // The assert was never accepted, so there is nothing to deassert.
                        irq_reg     <= 1'b0;
                        assert_reg  <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end

                INTX_ACTIVE: begin
                    if (!ie_s || int_mask) begin
                        irq_reg     <= 1'b1;
                        assert_reg  <= 1'b0;
                        tmo_cnt_reg <= 16'd0;
                        state_reg   <= INTX_DREQ;
                    end
                end

                INTX_DREQ: begin
                    tmo_cnt_reg <= sat_inc16(tmo_cnt_reg);
                    if (cfg_interrupt_rdy) begin
                        irq_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (tmo_hit) begin
                        irq_reg      <= 1'b0;
                        timeout_reg  <= 1'b1;
                        hold_cnt_reg <= 32'd0;
                        state_reg    <= HOLDOFF;
                    end
                end

                default: begin
                    irq_reg    <= 1'b0;
                    assert_reg <= 1'b0;
                    di_reg     <= 8'h00;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign cfg_interrupt        = irq_reg;
    assign cfg_interrupt_assert = assert_reg;
    assign cfg_interrupt_di     = di_reg;
    assign int_busy             = (state_reg != IDLE);
    assign int_timeout          = timeout_reg;

`ifdef AHCI_INT_COUNT_EN
    logic [31:0] count_reg;
    logic        accept;

    assign accept = cfg_interrupt_rdy && ((state_reg == MSI_REQ) || (state_reg == INTX_AREQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 32'd0;
        end else if (accept) begin
            count_reg <= sat_inc32(count_reg);
        end
    end

    assign int_count = count_reg;
`endif

endmodule

// File: tb/tb_ahci_int_ctrl.sv
// Directed self-checking bench for ahci_int_ctrl (HOLDOFF_CYCLES=16, RDY_TIMEOUT=8).
// Stimulus changes 1 time unit after each rising edge; outputs are sampled there too.
module tb_ahci_int_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_enable = 1'b0;
    logic        int_mask = 1'b0;
    logic        msien = 1'b0;
    logic        rdy = 1'b0;
    logic        cfg_interrupt;
    logic        cfg_interrupt_assert;
    logic [7:0]  cfg_interrupt_di;
    logic        int_busy;
    logic        int_timeout;
`ifdef AHCI_INT_COUNT_EN
    logic [31:0] int_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ahci_int_ctrl #(
        .HOLDOFF_CYCLES (16),
        .RDY_TIMEOUT    (8),
        .MSI_VECTOR     (8'h00)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .int_enable              (int_enable),
        .int_mask                (int_mask),
        .cfg_interrupt_msienable (msien),
        .cfg_interrupt_rdy       (rdy),
        .cfg_interrupt           (cfg_interrupt),
        .cfg_interrupt_assert    (cfg_interrupt_assert),
        .cfg_interrupt_di        (cfg_interrupt_di),
        .int_busy                (int_busy),
        .int_timeout             (int_timeout)
`ifdef AHCI_INT_COUNT_EN
        ,
        .int_count               (int_count)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && int_busy; i++) tick();
        check(tag, {31'd0, int_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hcnt, n_req, first, last, min_gap, n_a, n_d, a_e, d_e, cnt;
        logic seen;

        // Reset state
        tick(3);
        check("rst_irq",     {31'd0, cfg_interrupt}, 0);
        check("rst_assert",  {31'd0, cfg_interrupt_assert}, 0);
        check("rst_di",      {24'd0, cfg_interrupt_di}, 0);
        check("rst_busy",    {31'd0, int_busy}, 0);
        check("rst_timeout", {31'd0, int_timeout}, 0);
`ifdef AHCI_INT_COUNT_EN
        check("rst_count", int_count, 0);
`endif
        rst = 1'b0;
        tick();

        // MSI accepted, rdy two cycles after the request
        msien = 1'b1; rdy = 1'b0; int_enable = 1'b1;
        tick(2);
        check("msi_lat2", {31'd0, cfg_interrupt}, 0);
        tick();
        check("msi_req",    {31'd0, cfg_interrupt}, 1);
        check("msi_di",     {24'd0, cfg_interrupt_di}, 8'h00);
        check("msi_assert", {31'd0, cfg_interrupt_assert}, 0);
        check("msi_busy",   {31'd0, int_busy}, 1);
        int_enable = 1'b0;
        tick();
        check("msi_req_held", {31'd0, cfg_interrupt}, 1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("msi_drop", {31'd0, cfg_interrupt}, 0);
        hcnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && int_busy; i++) begin
            hcnt++;
            seen |= cfg_interrupt;
            tick();
        end
        check("msi_holdoff_len", hcnt, 16);
        check("msi_holdoff_quiet", {31'd0, seen}, 0);

        // Stuck-high MSI with immediate rdy: one request every 18 cycles
        tick();
        rdy = 1'b1; int_enable = 1'b1;
        n_req = 0; first = 0; last = 0; min_gap = 1000;
        for (int e = 1; e <= 120; e++) begin
            tick();
            if (cfg_interrupt) begin
                if (n_req == 0) first = e;
                else if (e - last < min_gap) min_gap = e - last;
                last = e;
                n_req++;
            end
            if (e == 100) int_enable = 1'b0;
        end
        rdy = 1'b0;
        check("stuck_first", first, 3);
        check("stuck_count", n_req, 6);
        check("stuck_gap", min_gap, 18);
        check("stuck_gap_ge17", {31'd0, (min_gap >= 17)}, 1);
        wait_idle("stuck_idle");

        // INTx: 50-cycle pulse, immediate rdy
        msien = 1'b0; rdy = 1'b1; int_enable = 1'b1;
        n_a = 0; n_d = 0; a_e = 0; d_e = 0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (cfg_interrupt) begin
                if (cfg_interrupt_assert) begin n_a++; a_e = e; end
                else begin n_d++; d_e = e; end
            end
            if (e == 50) int_enable = 1'b0;
        end
        check("intx_assert_edge", a_e, 3);
        check("intx_assert_n", n_a, 1);
        check("intx_deassert_n", n_d, 1);
        check("intx_deassert_edge", d_e, 53);
        check("intx_idle", {31'd0, int_busy}, 0);

        // Mask rising in INTX_ACTIVE forces the deassert
        int_enable = 1'b1;
        tick(5);
        int_mask = 1'b1;
        tick();
        check("mask_dreq_irq",    {31'd0, cfg_interrupt}, 1);
        check("mask_dreq_assert", {31'd0, cfg_interrupt_assert}, 0);
        tick(3);
        check("mask_stay_idle", {31'd0, int_busy}, 0);

        // Mask held blocks MSI; clearing it requests; reset mid-MSI_REQ
        msien = 1'b1; rdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= cfg_interrupt;
        end
        check("mask_block", {31'd0, seen}, 0);
        int_mask = 1'b0;
        tick();
        check("unmask_req", {31'd0, cfg_interrupt}, 1);
        rst = 1'b1; int_enable = 1'b0;
        tick();
        check("rst_mid_irq",  {31'd0, cfg_interrupt}, 0);
        check("rst_mid_busy", {31'd0, int_busy}, 0);
        rst = 1'b0;
        tick(3);

        // MSI ready timeout
        check("tmo_pre", {31'd0, int_timeout}, 0);
        int_enable = 1'b1;
        tick(3);
        int_enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cfg_interrupt; i++) begin
            cnt++;
            tick();
        end
        check("tmo_len", cnt, 8);
        check("tmo_flag", {31'd0, int_timeout}, 1);
        check("tmo_holdoff", {31'd0, int_busy}, 1);
        wait_idle("tmo_idle");
        tick(5);
        check("tmo_sticky", {31'd0, int_timeout}, 1);

        // INTx assert timeout goes straight to IDLE without deassert
        msien = 1'b0; int_enable = 1'b1;
        tick(3);
        int_enable = 1'b0;
        check("atmo_req", {31'd0, cfg_interrupt_assert}, 1);
        tick(8);
        check("atmo_drop", {31'd0, cfg_interrupt}, 0);
        check("atmo_idle", {31'd0, int_busy}, 0);
        tick();
        check("atmo_no_dreq", {31'd0, cfg_interrupt}, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tmo_cleared", {31'd0, int_timeout}, 0);
        tick(3);

        // Rdy on the timeout cycle is an acceptance
        msien = 1'b1; int_enable = 1'b1;
        tick(3);
        int_enable = 1'b0;
        tick(7);
        check("edge_req_still", {31'd0, cfg_interrupt}, 1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("edge_drop",    {31'd0, cfg_interrupt}, 0);
        check("edge_no_tmo",  {31'd0, int_timeout}, 0);
        check("edge_holdoff", {31'd0, int_busy}, 1);
        wait_idle("edge_idle");

`ifdef AHCI_INT_COUNT_EN
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        msien = 1'b1; rdy = 1'b1; int_enable = 1'b1;
        tick(40);
        int_enable = 1'b0;
        wait_idle("cnt_idle");
        check("cnt_three", int_count, 3);
        force dut.count_reg = 32'hFFFF_FFFF;
        tick();
        release dut.count_reg;
        int_enable = 1'b1;
        tick(3);
        int_enable = 1'b0;
        tick();
        wait_idle("cnt_sat_idle");
        check("cnt_saturate", int_count, 32'hFFFF_FFFF);
        rdy = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahci_int_ctrl.md
Name: ahci_int_ctrl

Overview:
- Downstream consumer of the AHCI BAR register block's `int_enable` level output.
- Converts that level into interrupt-request handshakes on the PCIe core configuration-interrupt interface (`cfg_interrupt*`, 7-series style).
- Delivers MSI when the host has enabled MSI; otherwise delivers legacy INTx with separate assert and deassert messages.
- Provides a re-trigger holdoff so a stuck-high `int_enable` cannot flood the link, and a ready-timeout so a silent core cannot deadlock the FSM.

Parameters:
HOLDOFF_CYCLES, 100000, idle cycles enforced after each delivered MSI before the next request.
RDY_TIMEOUT, 1024, cycles to wait for `cfg_interrupt_rdy` before abandoning a request.
MSI_VECTOR, 8'h00, value driven on `cfg_interrupt_di` for MSI.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
int_enable  in  1  interrupt level from the BAR register block
int_mask  in  1  1 = suppress new requests (from host write path)
cfg_interrupt_msienable  in  1  MSI enabled by host
cfg_interrupt_rdy  in  1  core accepted current request
cfg_interrupt  out  1  request strobe, held until rdy or timeout
cfg_interrupt_assert  out  1  INTx: 1 = assert message, 0 = deassert message
cfg_interrupt_di  out  8  MSI vector / INTx data (0 for INTx)
int_busy  out  1  FSM not in IDLE
int_timeout  out  1  sticky; set on any rdy timeout, cleared only by rst

Behaviour:
- Reset values: `cfg_interrupt`=0, `cfg_interrupt_assert`=0, `cfg_interrupt_di`=0, `int_busy`=0, `int_timeout`=0. All counters are 0 and the state is IDLE.
- `int_enable` passes through a 2-flop synchronizer. Every trigger decision uses the synchronized value `ie_s`. Input-to-request latency is 3 cycles: 2 sync flops, then the registered state change.
- `cfg_interrupt_msienable` is sampled only in IDLE. A change mid-transaction takes effect at the next return to IDLE.
- IDLE:
  - `ie_s`=1, `int_mask`=0 and msienable=1 → MSI_REQ.
  - `ie_s`=1, `int_mask`=0 and msienable=0 → INTX_AREQ.
- MSI_REQ:
  - Drive `cfg_interrupt`=1, `cfg_interrupt_assert`=0, `cfg_interrupt_di`=MSI_VECTOR.
  - On rdy: drop `cfg_interrupt` the next cycle and go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES, then return to IDLE. A still-high `ie_s` re-triggers at that point (level semantics).
- INTX_AREQ: drive `cfg_interrupt`=1, `cfg_interrupt_assert`=1. On rdy → INTX_ACTIVE.
- INTX_ACTIVE:
  - `cfg_interrupt`=0.
  - Remain while `ie_s`=1.
  - `ie_s`=0 or `int_mask`=1 → INTX_DREQ.
- INTX_DREQ: drive `cfg_interrupt`=1, `cfg_interrupt_assert`=0. On rdy → IDLE.
- Timeout counter:
  - Runs in every *REQ state and resets on entry to each one.
  - Reaching RDY_TIMEOUT-1 without rdy: drop `cfg_interrupt`, set `int_timeout`.
  - MSI_REQ and INTX_DREQ then go to HOLDOFF.
  - INTX_AREQ goes to IDLE without a deassert message, since the assert was never accepted.
- Rdy outside a *REQ state is ignored.
- Rdy on the same cycle as the timeout counts as accepted; no timeout is flagged.
- `int_mask` rising during MSI_REQ or INTX_AREQ does not cancel the request in flight. Masking takes effect in IDLE or INTX_ACTIVE.
- Counters: holdoff counter is 32-bit, timeout counter is 16-bit. Both saturate and never wrap.
- `rst` mid-transaction returns to IDLE immediately with `cfg_interrupt`=0. No deassert message is sent; the core is reset alongside.
- `int_busy` = (state != IDLE), registered.

Optional Feature:
- Macro: `AHCI_INT_COUNT_EN`.
- Defined:
  - Adds output port `int_count` [31:0].
  - Increments on every accepted MSI or INTx assert (rdy seen in MSI_REQ or INTX_AREQ).
  - Saturates at 32'hFFFFFFFF; reset value 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package `ahci_int_pkg`:
  - state enum `int_state_t` {IDLE, MSI_REQ, HOLDOFF, INTX_AREQ, INTX_ACTIVE, INTX_DREQ}.
  - Default constants for HOLDOFF_CYCLES, RDY_TIMEOUT, MSI_VECTOR.
- One sub-module, `ahci_int_sync2`: the 2-flop synchronizer, reused for `int_mask` if needed.

Test Plan:
- MSI accepted: msienable=1, raise `int_enable`, rdy 2 cycles after the request → `cfg_interrupt` high for 2 cycles; `di`=8'h00, `assert`=0. State is HOLDOFF for exactly HOLDOFF_CYCLES (set to 16 in the bench).
- Stuck-high MSI: hold `int_enable`=1 for 100 cycles with HOLDOFF_CYCLES=16, rdy immediate → no two requests closer than 17 cycles; requests repeat.
- INTx cycle: msienable=0, `int_enable` pulse of 50 cycles, rdy immediate → one assert message (`assert`=1), then a deassert message (`assert`=0) 3 cycles after `int_enable` falls.
- Rdy timeout: RDY_TIMEOUT=8, rdy held 0 → `cfg_interrupt` drops after 8 cycles; `int_timeout`=1 and stays 1 until rst.
- Mask and reset: `int_mask`=1 before `int_enable` → no request. Then reset asserted in MSI_REQ → `cfg_interrupt`=0 the next cycle and state IDLE.
- `AHCI_INT_COUNT_EN`: 3 accepted MSIs → `int_count`=3. Preload 32'hFFFFFFFF and accept one more → value stays 32'hFFFFFFFF.
